// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem read, output register.
// FETCH_MISALIGN_CHECK_EN enables misaligned-redirect trap into HALT.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_DROP, S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        vld_q, vld_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        err_q, err_d;

  logic hs, load, consume, misalign;
  logic [31:0] tgt;

  assign imem_req_valid = (state_q == S_REQ) && (!vld_q || id_ready);
  assign imem_addr      = pc_q;
  assign hs      = imem_req_valid && imem_req_ready;
  assign load    = (state_q == S_WAIT) && imem_rsp_valid;
  assign consume = vld_q && id_ready && (state_q != S_HALT);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign = redirect_target[1:0] != 2'b00;
  assign tgt      = redirect_target;
`else
  assign misalign = 1'b0;
  assign tgt      = {redirect_target[31:2], 2'b00};
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ:  if (hs) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rsp_valid) begin
          vld_d   = 1'b1;
          instr_d = imem_rsp_data;
          ipc_d   = pc_q;
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      S_DROP: if (imem_rsp_valid) state_d = S_REQ;
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase

    if (consume && !load) begin
      vld_d   = 1'b0;
      instr_d = NOP_INSTR;
    end

    // Redirect overrides everything above, including a same-cycle load.
    if (redirect_valid && state_q != S_HALT) begin
      vld_d   = 1'b0;
      instr_d = NOP_INSTR;
      if (misalign) begin
        err_d   = 1'b1;
        state_d = S_HALT;
      end else begin
        pc_d = tgt;
        unique case (state_q)
          S_REQ:   state_d = hs ? S_DROP : S_REQ;
          S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
          S_DROP:  state_d = S_DROP;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
      instr_q <= NOP_INSTR;
      ipc_q   <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      err_q   <= err_d;
    end
  end

  assign if_valid  = vld_q;
  assign if_instr  = instr_q;
  assign if_pc     = ipc_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Expectations depend on FETCH_MISALIGN_CHECK_EN for the misaligned redirect.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_err;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".req"},   32'(imem_req_valid), 32'd0);
    chk({tag, ".addr"},  imem_addr, 32'h0);
    chk({tag, ".vld"},   32'(if_valid), 32'd0);
    chk({tag, ".instr"}, if_instr, NOP);
    chk({tag, ".pc"},    if_pc, 32'h0);
    chk({tag, ".err"},   32'(fetch_err), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    #12;
    chk_reset("rst");
    @(negedge clk);
    rst = 1'b0;
    settle();
    chk("c0.req", 32'(imem_req_valid), 32'd0);

    // zero-wait stream
    step();
    chk("c1.req", 32'(imem_req_valid), 32'd1);
    chk("c1.addr", imem_addr, 32'h0);
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0050_0093;
    settle();
    chk("c2.req", 32'(imem_req_valid), 32'd0);
    step();
    imem_rsp_valid = 1'b0;
    settle();
    chk("c3.vld", 32'(if_valid), 32'd1);
    chk("c3.pc", if_pc, 32'h0);
    chk("c3.instr", if_instr, 32'h0050_0093);
    chk("c3.req", 32'(imem_req_valid), 32'd1);
    chk("c3.addr", imem_addr, 32'h4);
    step();
    chk("c4.vld", 32'(if_valid), 32'd0);
    chk("c4.instr", if_instr, NOP);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h00A0_0113;
    step();
    imem_rsp_valid = 1'b0;
    chk("c5.vld", 32'(if_valid), 32'd1);
    chk("c5.pc", if_pc, 32'h4);
    chk("c5.instr", if_instr, 32'h00A0_0113);

    // decode stall
    id_ready = 1'b0;
    settle();
    chk("stall.req0", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall.vld", 32'(if_valid), 32'd1);
      chk("stall.instr", if_instr, 32'h00A0_0113);
      chk("stall.req", 32'(imem_req_valid), 32'd0);
    end
    id_ready = 1'b1;
    imem_req_ready = 1'b0;
    settle();
    chk("unstall.req", 32'(imem_req_valid), 32'd1);
    chk("unstall.addr", imem_addr, 32'h8);

    // memory backpressure
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp.req", 32'(imem_req_valid), 32'd1);
      chk("bp.addr", imem_addr, 32'h8);
      chk("bp.vld", 32'(if_valid), 32'd0);
    end
    imem_req_ready = 1'b1;
    step();

    // redirect in WAIT, stale response one cycle later
    redirect_valid = 1'b1;
    redirect_target = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("drop.req", 32'(imem_req_valid), 32'd0);
    chk("drop.addr", imem_addr, 32'h100);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    chk("drop.vld", 32'(if_valid), 32'd0);
    chk("drop.instr", if_instr, NOP);
    chk("rd.req", 32'(imem_req_valid), 32'd1);
    chk("rd.addr", imem_addr, 32'h100);
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h1111_1111;
    step();
    imem_rsp_valid = 1'b0;
    chk("rd.pc", if_pc, 32'h100);
    chk("rd.instr", if_instr, 32'h1111_1111);
    chk("rd.next", imem_addr, 32'h104);
    step();

    // redirect coinciding with response
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h2222_2222;
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    chk("co.vld", 32'(if_valid), 32'd0);
    chk("co.instr", if_instr, NOP);
    chk("co.req", 32'(imem_req_valid), 32'd1);
    chk("co.addr", imem_addr, 32'hFFFF_FFFC);
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h3333_3333;
    step();
    imem_rsp_valid = 1'b0;
    chk("wrap.pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap.instr", if_instr, 32'h3333_3333);
    chk("wrap.addr", imem_addr, 32'h0);

    // redirect in REQ with handshake -> DROP
    redirect_valid = 1'b1;
    redirect_target = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("rq.req", 32'(imem_req_valid), 32'd0);
    chk("rq.addr", imem_addr, 32'h200);
    chk("rq.vld", 32'(if_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h4444_4444;
    step();
    imem_rsp_valid = 1'b0;
    chk("rq.vld2", 32'(if_valid), 32'd0);
    chk("rq.req2", 32'(imem_req_valid), 32'd1);
    chk("rq.addr2", imem_addr, 32'h200);

    // misaligned redirect in REQ without handshake
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h302;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis.err", 32'(fetch_err), 32'd1);
    chk("mis.req", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      imem_rsp_valid = 1'b1;
      redirect_valid = (i == 1);
      redirect_target = 32'h400;
      step();
      chk("halt.req", 32'(imem_req_valid), 32'd0);
      chk("halt.err", 32'(fetch_err), 32'd1);
      chk("halt.vld", 32'(if_valid), 32'd0);
    end
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
`else
    chk("mis.err", 32'(fetch_err), 32'd0);
    chk("mis.req", 32'(imem_req_valid), 32'd1);
    chk("mis.addr", imem_addr, 32'h300);
`endif

    // async reset mid-transaction, stale response after release
    step();
    @(negedge clk);
    rst = 1'b1;
    settle();
    chk_reset("mid");
    @(negedge clk);
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h5555_5555;
    step();
    imem_rsp_valid = 1'b0;
    chk("post.vld", 32'(if_valid), 32'd0);
    chk("post.req", 32'(imem_req_valid), 32'd1);
    chk("post.addr", imem_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
